noc_local_interface: RTL

- Network interface between a PageRank processing element (PE) and the Local port of its NoC router.
- Injection path: accepts PE updates, computes the route, builds flits, and buffers them. It writes flits into the router's Local input FIFO under full/almost-full back-pressure.
- Ejection path: takes flits from the router's Local output, buffers them, and presents the stripped payload to the PE on a valid/ready handshake.

---
 rtl/noc_local_interface.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/noc_local_interface.sv
// Network interface between a PageRank PE and the Local port of its ring router.
//   Injection: PE update -> route lookup -> flit {payload, port, valid} -> inj FIFO
//              -> registered write into the router Local input (flit_out/flit_write)
//              under router_full / router_almost_full back-pressure.
//   Ejection:  router Local output (ej_write/ej_flit) -> ej FIFO -> PE payload on
//              ej_valid/ej_ready; flits arriving while full are dropped and counted.
// Ports:
//   clk, reset (async active-low)
//   inj_valid/inj_ready/inj_dst/inj_payload           PE injection handshake
//   flit_out/flit_write/router_full/router_almost_full router Local input
//   ej_write/ej_flit/ej_full/ej_almost_full            router Local output
//   ej_valid/ej_ready/ej_payload                       PE ejection handshake
//   drop_cnt                                           saturating dropped-flit count
module noc_local_interface #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned N_NODES   = 4,
  parameter int unsigned LOCAL_ID  = 0,
  parameter int unsigned NODE_BITS = 2,
  parameter int unsigned INJ_DEPTH = 4,
  parameter int unsigned EJ_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inj_valid,
  output logic                 inj_ready,
  input  logic [NODE_BITS-1:0] inj_dst,
  input  logic [WIDTH-4:0]     inj_payload,
  output logic [WIDTH-1:0]     flit_out,
  output logic                 flit_write,
  input  logic                 router_full,
  input  logic                 router_almost_full,
  input  logic                 ej_write,
  input  logic [WIDTH-1:0]     ej_flit,
  output logic                 ej_full,
  output logic                 ej_almost_full,
  output logic                 ej_valid,
  input  logic                 ej_ready,
  output logic [WIDTH-4:0]     ej_payload,
  output logic [7:0]           drop_cnt
);

  localparam int unsigned INJ_PW = $clog2(INJ_DEPTH);
  localparam int unsigned INJ_CW = INJ_PW + 1;
  localparam int unsigned EJ_PW  = $clog2(EJ_DEPTH);
  localparam int unsigned EJ_CW  = EJ_PW + 1;

  // ---------------------------------------------------------------- route
  logic [31:0]      routeSum;
  logic [31:0]      routeDiff;
  logic [1:0]       injPort;
  logic [WIDTH-1:0] injFlit;

  // Ring distance going East; anything past half the ring is shorter going West.
  always_comb begin
    routeSum  = 32'(inj_dst) + N_NODES - LOCAL_ID;
    routeDiff = (routeSum >= N_NODES) ? (routeSum - N_NODES) : routeSum;
    if (32'(inj_dst) >= N_NODES) begin
      injPort = 2'b11;
    end else if (routeDiff == 32'd0) begin
      injPort = 2'b10;
    end else if (routeDiff <= (N_NODES / 2)) begin
      injPort = 2'b00;
    end else begin
      injPort = 2'b01;
    end
  end

  assign injFlit = {inj_payload, injPort, 1'b1};

  // ---------------------------------------------------------------- injection FIFO
  logic [WIDTH-1:0]  injMem [INJ_DEPTH];
  logic [INJ_PW-1:0] injWrPtr;
  logic [INJ_PW-1:0] injRdPtr;
  logic [INJ_CW-1:0] injCount;
  logic              injPush;
  logic              injSend;

  assign inj_ready = (injCount < INJ_CW'(INJ_DEPTH));
  assign injPush   = inj_valid & inj_ready;
  // While the router is almost full, never write on two consecutive cycles.
  assign injSend   = (injCount != '0) & ~router_full & ~(router_almost_full & flit_write);

  // Flit storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (injPush) begin
      injMem[injWrPtr] <= injFlit;
    end
  end

  // Pointers, occupancy and the registered router write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      injWrPtr   <= '0;
      injRdPtr   <= '0;
      injCount   <= '0;
      flit_write <= 1'b0;
      flit_out   <= '0;
    end else begin
      if (injPush) begin
        injWrPtr <= injWrPtr + INJ_PW'(1);
      end
      if (injSend) begin
        injRdPtr <= injRdPtr + INJ_PW'(1);
      end
      case ({injPush, injSend})
        2'b10:   injCount <= injCount + INJ_CW'(1);
        2'b01:   injCount <= injCount - INJ_CW'(1);
        default: injCount <= injCount;
      endcase
      flit_write <= injSend;
      flit_out   <= injSend ? injMem[injRdPtr] : '0;
    end
  end

  // ---------------------------------------------------------------- ejection FIFO
  logic [WIDTH-1:0] ejMem [EJ_DEPTH];
  logic [EJ_PW-1:0] ejWrPtr;
  logic [EJ_PW-1:0] ejRdPtr;
  logic [EJ_CW-1:0] ejCount;
  logic [EJ_CW-1:0] ejCountNext;
  logic             ejHit;
  logic             ejAccept;
  logic             ejDrop;
  logic             ejPop;

  assign ejHit      = ej_write & ej_flit[0];
  // Space is judged on the registered count, so a same-cycle pop does not save a flit.
  assign ejAccept   = ejHit & (ejCount < EJ_CW'(EJ_DEPTH));
  assign ejDrop     = ejHit & ~(ejCount < EJ_CW'(EJ_DEPTH));
  assign ej_valid   = (ejCount != '0);
  assign ejPop      = ej_valid & ej_ready;
  assign ej_payload = ejMem[ejRdPtr][WIDTH-1:3];

  // Next occupancy; flags are registered from it so they match the count.
  always_comb begin
    ejCountNext = ejCount;
    case ({ejAccept, ejPop})
      2'b10:   ejCountNext = ejCount + EJ_CW'(1);
      2'b01:   ejCountNext = ejCount - EJ_CW'(1);
      default: ejCountNext = ejCount;
    endcase
  end

  // Flit storage for the ejection side.
  always_ff @(posedge clk) begin
    if (ejAccept) begin
      ejMem[ejWrPtr] <= ej_flit;
    end
  end

  // Pointers, occupancy, status flags and drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ejWrPtr        <= '0;
      ejRdPtr        <= '0;
      ejCount        <= '0;
      ej_full        <= 1'b0;
      ej_almost_full <= 1'b0;
      drop_cnt       <= 8'd0;
    end else begin
      if (ejAccept) begin
        ejWrPtr <= ejWrPtr + EJ_PW'(1);
      end
      if (ejPop) begin
        ejRdPtr <= ejRdPtr + EJ_PW'(1);
      end
      ejCount        <= ejCountNext;
      ej_full        <= (ejCountNext == EJ_CW'(EJ_DEPTH));
      ej_almost_full <= (ejCountNext >= EJ_CW'(EJ_DEPTH - 1));
      if (ejDrop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
